// File: rtl/logic_gate_pkg.sv
// Shared definitions for the exhaustive gate sweeper: gate encodings,
// FSM state type and the largest supported gate width.
package logic_gate_pkg;

  localparam int MAX_N = 8;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5
  } gate_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DONE
  } sweep_state_e;

  // Encodings 6 and 7 have no gate behind them.
  function automatic logic is_legal_op(input logic [2:0] op);
    return op <= OP_XNOR;
  endfunction

endpackage

// File: rtl/gate_eval.sv
// N-input combinational gate: reduces the whole vector with the selected
// operator; illegal selections evaluate to 0.
module gate_eval
  import logic_gate_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] vec,
  input  logic [2:0]   op,
  output logic         y
);

  always_comb begin
    y = 1'b0;
    case (op)
      OP_AND:  y = &vec;
      OP_OR:   y = |vec;
      OP_NAND: y = ~&vec;
      OP_NOR:  y = ~|vec;
      OP_XOR:  y = ^vec;
      OP_XNOR: y = ~^vec;
      default: y = 1'b0;
    endcase
  end

endmodule

// File: rtl/logic_gate_sweep.sv
// Walks every N-bit input vector through one gate, presenting each vector
// and its result for one cycle and collecting the full truth table.
module logic_gate_sweep
  import logic_gate_pkg::*;
#(
  parameter int N = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op,
  output logic              busy,
  output logic              valid,
  output logic [N-1:0]      vec_out,
  output logic              y,
  output logic [2**N-1:0]   tt,
  output logic              done,
  output logic              err
);

  localparam logic [N-1:0] LAST_VEC = {N{1'b1}};

  if (N < 2 || N > MAX_N) begin : g_bad_n
    $error("logic_gate_sweep: N must lie in 2..%0d", MAX_N);
  end

  sweep_state_e      r_state;
  sweep_state_e      w_next_state;
  logic [N-1:0]      r_cnt;
  logic [2:0]        r_op;
  logic [2**N-1:0]   r_tt;
  logic              r_err;
  logic              w_accept;
  logic              w_legal;
  logic              w_sweep;
  logic              w_y;

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_legal  = is_legal_op(op);
  assign w_sweep  = (r_state == ST_SWEEP);

  gate_eval #(.N(N)) u_gate_eval (
    .vec (r_cnt),
    .op  (r_op),
    .y   (w_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next_state = w_legal ? ST_SWEEP : ST_DONE;
      ST_SWEEP: if (r_cnt == LAST_VEC) w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // The counter parks on the last vector rather than wrapping, so the
  // DONE cycle never sees a stray vector 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_op  <= '0;
      r_tt  <= '0;
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_op  <= op;
      r_tt  <= '0;
      r_err <= !w_legal;
    end else if (w_sweep) begin
      r_tt[r_cnt] <= w_y;
      if (r_cnt != LAST_VEC) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign busy    = w_sweep;
  assign valid   = w_sweep;
  assign vec_out = w_sweep ? r_cnt : '0;
  assign y       = w_sweep & w_y;
  assign tt      = r_tt;
  assign done    = (r_state == ST_DONE);
  assign err     = r_err;

endmodule

// File: tb/tb_logic_gate_sweep.sv
// Scoreboard bench for logic_gate_sweep at N=2 and N=3: stimulus queues the
// expected vectors and done pulse, per-instance monitors pop and compare.
module tb_logic_gate_sweep;

  typedef struct {
    bit         isDone;
    int         vec;
    bit         y;
    logic [7:0] tt;
    bit         err;
    int         cyc;
  } exp_t;

  logic       clk;
  int         cyc;
  int         vecCount;
  int         failCount;
  exp_t       q2[$];
  exp_t       q3[$];
  exp_t       e2;
  exp_t       e3;

  logic       rst_n2, start2, busy2, valid2, y2, done2, err2;
  logic [2:0] op2;
  logic [1:0] vecOut2;
  logic [3:0] tt2;
  logic       rst_n3, start3, busy3, valid3, y3, done3, err3;
  logic [2:0] op3;
  logic [2:0] vecOut3;
  logic [7:0] tt3;

  logic_gate_sweep #(.N(2)) dut2 (
    .clk(clk), .rst_n(rst_n2), .start(start2), .op(op2), .busy(busy2),
    .valid(valid2), .vec_out(vecOut2), .y(y2), .tt(tt2), .done(done2), .err(err2)
  );

  logic_gate_sweep #(.N(3)) dut3 (
    .clk(clk), .rst_n(rst_n3), .start(start3), .op(op3), .busy(busy3),
    .valid(valid3), .vec_out(vecOut3), .y(y3), .tt(tt3), .done(done3), .err(err3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    vecCount++;
    if (act !== expv) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input int which, input exp_t e);
    if (which == 2) q2.push_back(e);
    else            q3.push_back(e);
  endtask

  // Start is held for the current cycle; vector k is due k+1 cycles later.
  task automatic applyStimulus(input int which, input logic [2:0] opv, input logic [7:0] ttExp);
    int   n;
    int   c;
    bit   legal;
    exp_t e;
    n     = (which == 2) ? 2 : 3;
    c     = cyc;
    legal = (opv <= 3'd5);
    if (legal) begin
      for (int k = 0; k < (1 << n); k++) begin
        e = '{isDone: 1'b0, vec: k, y: ttExp[k], tt: 8'h00, err: 1'b0, cyc: c + 1 + k};
        pushExp(which, e);
      end
    end
    e = '{isDone: 1'b1, vec: 0, y: 1'b0, tt: legal ? ttExp : 8'h00, err: !legal,
          cyc: legal ? c + 1 + (1 << n) : c + 1};
    pushExp(which, e);
    if (which == 2) begin op2 = opv; start2 = 1'b1; end
    else            begin op3 = opv; start3 = 1'b1; end
    tick();
    start2 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic waitDrained(input int which);
    for (int i = 0; i < 200; i++) begin
      if (((which == 2) ? q2.size() : q3.size()) == 0) break;
      tick();
    end
    tick();
    tick();
    checkOutput((which == 2) ? "n2 queue drained" : "n3 queue drained",
                (which == 2) ? q2.size() : q3.size(), 0);
  endtask

  always @(negedge clk) begin
    if (valid2 || done2) begin
      if (q2.size() == 0) begin
        checkOutput("n2 unexpected output", {valid2, done2}, 0);
      end else begin
        e2 = q2.pop_front();
        checkOutput("n2 cycle", cyc, e2.cyc);
        checkOutput("n2 done", done2, e2.isDone);
        checkOutput("n2 valid", valid2, !e2.isDone);
        if (!e2.isDone) begin
          checkOutput("n2 vec_out", vecOut2, e2.vec);
          checkOutput("n2 y", y2, e2.y);
          checkOutput("n2 busy", busy2, 1);
        end else begin
          checkOutput("n2 tt", tt2, e2.tt);
          checkOutput("n2 err", err2, e2.err);
          checkOutput("n2 done-cycle outs", {busy2, vecOut2, y2}, 0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (valid3 || done3) begin
      if (q3.size() == 0) begin
        checkOutput("n3 unexpected output", {valid3, done3}, 0);
      end else begin
        e3 = q3.pop_front();
        checkOutput("n3 cycle", cyc, e3.cyc);
        checkOutput("n3 done", done3, e3.isDone);
        checkOutput("n3 valid", valid3, !e3.isDone);
        if (!e3.isDone) begin
          checkOutput("n3 vec_out", vecOut3, e3.vec);
          checkOutput("n3 y", y3, e3.y);
          checkOutput("n3 busy", busy3, 1);
        end else begin
          checkOutput("n3 tt", tt3, e3.tt);
          checkOutput("n3 err", err3, e3.err);
          checkOutput("n3 done-cycle outs", {busy3, vecOut3, y3}, 0);
        end
      end
    end
  end

  initial begin
    exp_t e;
    int   c;
    vecCount  = 0;
    failCount = 0;
    rst_n2 = 1'b0; start2 = 1'b0; op2 = 3'd0;
    rst_n3 = 1'b0; start3 = 1'b0; op3 = 3'd0;
    repeat (3) tick();
    checkOutput("n2 reset outputs", {busy2, valid2, vecOut2, y2, tt2, done2, err2}, 0);
    checkOutput("n3 reset outputs", {busy3, valid3, vecOut3, y3, tt3, done3, err3}, 0);
    rst_n2 = 1'b1;
    rst_n3 = 1'b1;
    tick();

    $display("[TB] N=2 sweeps over the legal gates");
    applyStimulus(2, 3'd0, 8'b0000_1000);
    waitDrained(2);
    checkOutput("n2 tt held after AND", tt2, 4'b1000);
    applyStimulus(2, 3'd4, 8'b0000_0110);
    waitDrained(2);
    applyStimulus(2, 3'd1, 8'b0000_1110);
    waitDrained(2);
    applyStimulus(2, 3'd2, 8'b0000_0111);
    waitDrained(2);
    applyStimulus(2, 3'd5, 8'b0000_1001);
    waitDrained(2);

    $display("[TB] illegal op handling");
    applyStimulus(2, 3'd6, 8'h00);
    waitDrained(2);
    checkOutput("n2 err held", err2, 1);
    checkOutput("n2 tt after illegal", tt2, 0);
    applyStimulus(2, 3'd7, 8'h00);
    waitDrained(2);

    $display("[TB] N=3 sweeps");
    applyStimulus(3, 3'd3, 8'b0000_0001);
    waitDrained(3);
    applyStimulus(3, 3'd2, 8'b0111_1111);
    waitDrained(3);
    applyStimulus(3, 3'd4, 8'b1001_0110);
    waitDrained(3);

    $display("[TB] start and op change mid-sweep");
    applyStimulus(2, 3'd0, 8'b0000_1000);
    tick();
    start2 = 1'b1;
    op2    = 3'd1;
    tick();
    start2 = 1'b0;
    waitDrained(2);
    repeat (4) tick();
    checkOutput("n2 tt after ignored start", tt2, 4'b1000);
    op2 = 3'd0;

    $display("[TB] reset in the middle of a sweep");
    c = cyc;
    for (int k = 0; k < 3; k++) begin
      e = '{isDone: 1'b0, vec: k, y: (k == 3), tt: 8'h00, err: 1'b0, cyc: c + 1 + k};
      pushExp(2, e);
    end
    op2 = 3'd0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick();
    tick();
    rst_n2 = 1'b0;
    tick();
    checkOutput("n2 outputs after mid reset", {busy2, valid2, vecOut2, y2, tt2, done2, err2}, 0);
    checkOutput("n2 queue after mid reset", q2.size(), 0);
    rst_n2 = 1'b1;
    repeat (3) tick();
    applyStimulus(2, 3'd5, 8'b0000_1001);
    waitDrained(2);

    $display("[TB] reset has priority over start");
    rst_n3 = 1'b0;
    start3 = 1'b1;
    op3    = 3'd0;
    tick();
    start3 = 1'b0;
    rst_n3 = 1'b1;
    tick();
    checkOutput("n3 idle after reset+start", {busy3, valid3, vecOut3, y3, tt3, done3, err3}, 0);
    repeat (12) tick();
    checkOutput("n3 queue after reset+start", q3.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
    $finish;
  end

endmodule

// File: doc/logic_gate_sweep.md
LOGIC_GATE_SWEEP -- requirements
Module: logic_gate_sweep

Interface
REQ-001 SHALL have one parameter: N, default 2, gate input count, legal range 2..8.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-004 SHALL have port start, input, 1, request one exhaustive sweep.
REQ-005 SHALL have port op, input, 3, gate select: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6..7 illegal.
REQ-006 SHALL have port busy, output, 1, high while the state is SWEEP.
REQ-007 SHALL have port valid, output, 1, vec_out/y pair is current.
REQ-008 SHALL have port vec_out, output, N, input vector currently applied.
REQ-009 SHALL have port y, output, 1, gate result for vec_out.
REQ-010 SHALL have port tt, output, 2**N, truth table; bit k = result for vector k.
REQ-011 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port err, output, 1, last start carried an illegal op; valid while done=1 and held until the next accepted start.

Function
REQ-013 SHALL implement FSM states IDLE, SWEEP, DONE.
REQ-014 SHALL accept start only in IDLE; accepting SHALL latch op, clear tt and err, and load cnt=0.
REQ-015 SHALL go IDLE->SWEEP on an accepted start with a legal op, and IDLE->DONE with err=1 on an accepted start with an illegal op.
REQ-016 SHALL, in each SWEEP cycle k (k=0..2**N-1), present registered vec_out=k, y=f(op,k), valid=1, and busy=1.
REQ-017 SHALL write tt[k]=f(op,k) in the same cycle that vector k is presented.
REQ-018 SHALL evaluate f as the reduction of the latched op over all N bits of the vector; NAND, NOR and XNOR SHALL be inverted AND, OR and XOR.
REQ-019 SHALL move SWEEP->DONE after cnt=2**N-1, with no wrap to 0 and no extra vector.
REQ-020 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-021 SHALL place the first valid cycle one cycle after start is sampled, and done 2**N+1 cycles after start is sampled.
REQ-022 SHALL ignore start in SWEEP and DONE; it is not queued.
REQ-023 SHALL ignore op changes after acceptance; the latched op governs the whole sweep.
REQ-024 SHALL hold valid=0, y=0 and vec_out=0 outside SWEEP.
REQ-025 SHALL hold tt stable from DONE until the next accepted start.
REQ-026 SHALL clear tt and err on start and perform no other tt update on an illegal op, so tt=0 at done.

Reset
REQ-027 SHALL, when rst_n=0 at a clock edge, force state IDLE, cnt=0, latched op=0, and busy, valid, vec_out, y, tt, done and err all 0.
REQ-028 SHALL abandon any sweep in progress on reset mid-operation, with no done pulse.
REQ-029 SHALL give reset priority over start when both are active in the same cycle.

Structure
REQ-030 SHALL place op encodings, the state typedef and the maximum N constant in shared package logic_gate_pkg.
REQ-031 SHALL isolate the N-input combinational evaluator as sub-module gate_eval (inputs vec and op, output y); the FSM, counter and tt register SHALL live in logic_gate_sweep.

Verification
REQ-032 SHALL cover: N=2, op=0, start pulse -> valid for 4 cycles, vec 0..3, y 0,0,0,1; done 5 cycles after start; tt=4'b1000.
REQ-033 SHALL cover: N=2, op=4 -> y sequence 0,1,1,0; tt=4'b0110; err=0.
REQ-034 SHALL cover: N=3, op=3 -> tt=8'b00000001, done 9 cycles after start; then op=2 -> tt=8'b01111111.
REQ-035 SHALL cover: op=6 start -> no valid cycles, done next cycle, err=1, tt=0.
REQ-036 SHALL cover: start and op change asserted at cycle 2 of a sweep -> both ignored, tt matches the original op, exactly one done.
REQ-037 SHALL cover: rst_n=0 at vector 2 of an N=2 sweep -> next cycle all outputs 0 and IDLE; a fresh start then completes normally.
